// File: rtl/seq_accumulator_if.sv
// Sample-in / frame-result-out handshake bundle for seq_accumulator.
// master = upstream/downstream environment, slave = the accumulator.
interface seq_accumulator_if #(
    parameter int N = 8
);
    logic                in_valid;
    logic                in_ready;
    logic signed [N-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic signed [N-1:0] out_sum;
    logic                out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/seq_accumulator.sv
// Frame accumulator: sums LEN signed samples, holds the sum and a sticky overflow flag until taken.
// Build option: define ACC_SAT_EN to clamp the running sum on overflow instead of wrapping.
module seq_accumulator #(
    parameter int N   = 8,
    parameter int LEN = 4
) (
    input logic              clk,
    input logic              rstn,
    input logic              clr,
    seq_accumulator_if.slave bus
);
    localparam int               CNT_W = $clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LEN - 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t              state;
    logic signed [N-1:0] acc;
    logic [CNT_W-1:0]    cnt;
    logic                ovf;

    logic                accept_p0;
    logic signed [N-1:0] raw_p0;
    logic signed [N-1:0] sum_p0;
    logic                ovf_p0;

    function automatic logic ovf_detect(input logic signed [N-1:0] a,
                                        input logic signed [N-1:0] b,
                                        input logic signed [N-1:0] r);
        return (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
    endfunction

`ifdef ACC_SAT_EN
    localparam logic signed [N-1:0] SMAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SMIN = {1'b1, {(N-1){1'b0}}};

    // Overflow direction follows the (shared) operand sign.
    function automatic logic signed [N-1:0] saturate(input logic neg);
        return neg ? SMIN : SMAX;
    endfunction
`endif

    always_comb begin
        accept_p0 = (state == ACC) && bus.in_valid;
        raw_p0    = acc + bus.in_data;
        ovf_p0    = ovf_detect(acc, bus.in_data, raw_p0);
`ifdef ACC_SAT_EN
        sum_p0    = ovf_p0 ? saturate(acc[N-1]) : raw_p0;
`else
        sum_p0    = raw_p0;
`endif
    end

    // ---- stage p0 -> registered frame state ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            state <= ACC;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept_p0) begin
                        acc <= sum_p0;
                        cnt <= cnt + CNT_W'(1);
                        ovf <= ovf | ovf_p0;
                        if (cnt == LAST) state <= HOLD;
                    end
                end
                HOLD: begin
                    // The handshake cycle is a bubble: nothing is accepted until back in ACC.
                    if (bus.out_ready) begin
                        state <= ACC;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    assign bus.in_ready  = (state == ACC);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_seq_accumulator.sv
// Self-checking bench for seq_accumulator (N=8, LEN=4, plus a LEN=1 instance).
// Honours ACC_SAT_EN the same way the design does.
module tb_seq_accumulator;
    logic clk = 1'b0;
    logic rstn;
    logic clr;
    always #5 clk = ~clk;

    seq_accumulator_if #(.N(8)) bus ();
    seq_accumulator_if #(.N(8)) bus1 ();

    seq_accumulator #(.N(8), .LEN(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .bus  (bus)
    );

    seq_accumulator #(.N(8), .LEN(1)) dut1 (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr),
        .bus  (bus1)
    );

    typedef struct {
        logic [3:0][7:0] d;
        int              sum;
        bit              ovf;
    } vec_t;

    typedef struct packed {
        logic [7:0] sum;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0][7:0] mk(input int a, input int b, input int c, input int e);
        logic [3:0][7:0] r;
        r[0] = 8'(a);
        r[1] = 8'(b);
        r[2] = 8'(c);
        r[3] = 8'(e);
        return r;
    endfunction

    task automatic push(input int s, input bit o);
        exp_t e;
        e.sum = 8'(s);
        e.ovf = o;
        q.push_back(e);
    endtask

    // Reference: integer running sum, re-mapped into the 8-bit range after each add.
    function automatic void model(input logic [3:0][7:0] d, output int s, output bit o);
        int a;
        a = 0;
        o = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a = a + int'($signed(d[i]));
            if (a > 127 || a < -128) begin
                o = 1'b1;
`ifdef ACC_SAT_EN
                a = (a > 127) ? 127 : -128;
`else
                a = (a > 127) ? a - 256 : a + 256;
`endif
            end
        end
        s = a;
    endfunction

    task automatic send_n(input logic [3:0][7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            bit got;
            int w;
            bus.in_valid = 1'b1;
            bus.in_data  = $signed(d[i]);
            got = 1'b0;
            w   = 0;
            while (!got && w < 40) begin
                @(negedge clk);
                got = bus.in_ready;
                @(posedge clk);
                #1;
                w++;
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL accept_timeout sample=%0d in_ready=%0b expected=1", i, bus.in_ready);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 64) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d expected=0", q.size());
            q.delete();
        end
    endtask

    // Scoreboard: every result handshake pops one expected frame.
    always @(negedge clk) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result sum=%0d expected=none", bus.out_sum);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("frame_sum", int'(bus.out_sum), int'($signed(e.sum)));
                chk("frame_ovf", int'(bus.out_ovf), int'(e.ovf));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s;
        bit  o;
        int  v1[3];
        logic [3:0][7:0] rd;

        tbl[0] = '{mk(5, -10, 30, 10), 35, 1'b0};
`ifdef ACC_SAT_EN
        tbl[1] = '{mk(127, 1, 0, 0), 127, 1'b1};
        tbl[2] = '{mk(-128, -1, 0, 0), -128, 1'b1};
        tbl[3] = '{mk(100, 100, -100, -100), -73, 1'b1};
`else
        tbl[1] = '{mk(127, 1, 0, 0), -128, 1'b1};
        tbl[2] = '{mk(-128, -1, 0, 0), 127, 1'b1};
        tbl[3] = '{mk(100, 100, -100, -100), 0, 1'b1};
`endif
        tbl[4] = '{mk(-1, -2, -3, -4), -10, 1'b0};
        tbl[5] = '{mk(64, 63, 0, 0), 127, 1'b0};
        tbl[6] = '{mk(-64, -64, 0, 0), -128, 1'b0};
        v1[0] = 127;
        v1[1] = -128;
        v1[2] = -1;

        rstn = 1'b0;
        clr  = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_sum", int'(bus.out_sum), 0);
        chk("rst_out_ovf", int'(bus.out_ovf), 0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame with explicit timing around the result.
        push(35, 1'b0);
        send_n(mk(5, -10, 30, 10), 4);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_out_valid", int'(bus.out_valid), 1);
        chk("lat_in_ready", int'(bus.in_ready), 0);
        chk("lat_out_sum", int'(bus.out_sum), 35);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_out_valid", int'(bus.out_valid), 0);
        chk("after_in_ready", int'(bus.in_ready), 1);

        // Table vectors, frames back to back.
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            push(tbl[i].sum, tbl[i].ovf);
            send_n(tbl[i].d, 4);
        end
        bus.in_valid = 1'b0;
        drain();

        // Random frames against the integer model.
        for (int i = 0; i < 6; i++) begin
            rd = mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            model(rd, s, o);
            push(s, o);
            send_n(rd, 4);
        end
        bus.in_valid = 1'b0;
        drain();

        // Backpressure: result held, in_valid ignored while held.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        push(10, 1'b0);
        send_n(mk(1, 2, 3, 4), 4);
        bus.in_data = 8'sd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_out_valid", int'(bus.out_valid), 1);
            chk("hold_out_sum", int'(bus.out_sum), 10);
            chk("hold_in_ready", int'(bus.in_ready), 0);
            if (i < 2) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        push(28, 1'b0);
        send_n(mk(7, 7, 7, 7), 4);
        bus.in_valid = 1'b0;
        drain();

        // Clear mid-frame, with a coincident sample that must be dropped.
        @(posedge clk);
        #1;
        send_n(mk(50, 60, 0, 0), 2);
        bus.in_data = 8'sd100;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_in_ready", int'(bus.in_ready), 1);
        chk("clr_acc", int'(bus.out_sum), 0);
        @(posedge clk);
        #1;
        push(10, 1'b0);
        send_n(mk(1, 2, 3, 4), 4);
        bus.in_valid = 1'b0;
        drain();

        // Clear while holding discards the result.
        bus.out_ready = 1'b0;
        send_n(mk(100, 100, 9, 9), 4);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("clrhold_valid_before", int'(bus.out_valid), 1);
        chk("clrhold_ovf_before", int'(bus.out_ovf), 1);
        @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("clrhold_valid", int'(bus.out_valid), 0);
        chk("clrhold_ovf", int'(bus.out_ovf), 0);
        chk("clrhold_sum", int'(bus.out_sum), 0);

        // Asynchronous reset while holding.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send_n(mk(5, -10, 30, 10), 4);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("prerst_sum", int'(bus.out_sum), 35);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_out_valid", int'(bus.out_valid), 0);
        chk("arst_out_sum", int'(bus.out_sum), 0);
        chk("arst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        push(8, 1'b0);
        send_n(mk(2, 2, 2, 2), 4);
        bus.in_valid = 1'b0;
        drain();

        // Single-sample frames.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus1.in_valid = 1'b1;
            bus1.in_data  = 8'(v1[i]);
            @(negedge clk);
            chk("len1_in_ready", int'(bus1.in_ready), 1);
            @(posedge clk);
            #1;
            bus1.in_valid = 1'b0;
            @(negedge clk);
            chk("len1_out_valid", int'(bus1.out_valid), 1);
            chk("len1_out_sum", int'(bus1.out_sum), v1[i]);
            chk("len1_out_ovf", int'(bus1.out_ovf), 0);
        end
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
